mem_responder: RTL and testbench

- Memory-side responder for the multicycle controller's MemRead/MemWrite request strobes.
- Holds a unified instruction/data word array and serves byte, half and word accesses after a programmable number of wait states.
- Returns a one-cycle Ready pulse with read data or an error flag.
- Sits between the datapath's address/write-data registers and the IR/MDR load path.

---
 rtl/mem_responder_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_responder.sv | 132 +++++++++++++
 tb/tb_mem_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings and request payload for the mem_responder slice.
package mem_responder_pkg;

  localparam int unsigned MEMR_ADDR_W   = 32;
  localparam int unsigned MEMR_DATA_W   = 32;
  localparam int unsigned MEMR_CNT_W    = 4;
  localparam int unsigned MEMR_WAIT_MAX = 15;

  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    MEMR_IDLE = 2'd0,
    MEMR_WAIT = 2'd1,
    MEMR_RESP = 2'd2
  } memr_state_t;

  typedef struct packed {
    logic [MEMR_ADDR_W-1:0] addr;
    logic [MEMR_DATA_W-1:0] wdata;
    logic [1:0]             size;
    logic                   sign_ext;
    logic                   write;
    logic                   both;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for byte/half/word accesses plus size/alignment fault detect.
// MEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [1:0]             addr_lo,
  input  logic [1:0]             size,
  input  logic                   sign_ext,
  input  logic [MEMR_DATA_W-1:0] wdata,
  input  logic [MEMR_DATA_W-1:0] rword,
  output logic [3:0]             be_c,
  output logic [MEMR_DATA_W-1:0] wword_c,
  output logic [MEMR_DATA_W-1:0] rdata_c,
  output logic                   size_err_c,
  output logic                   misalign_c
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Half lanes use only addr_lo[1] and words ignore addr_lo, which is the forced alignment.
  always_comb begin
    be_c       = '0;
    wword_c    = '0;
    rdata_c    = '0;
    size_err_c = 1'b0;
    rbyte      = 8'(rword >> {addr_lo, 3'b000});
    rhalf      = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      MEM_SZ_B: begin
        be_c    = 4'(4'b0001 << addr_lo);
        wword_c = {4{wdata[7:0]}};
        rdata_c = {{24{sign_ext & rbyte[7]}}, rbyte};
      end
      MEM_SZ_H: begin
        be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword_c = {2{wdata[15:0]}};
        rdata_c = {{16{sign_ext & rhalf[15]}}, rhalf};
      end
      MEM_SZ_W: begin
        be_c    = 4'b1111;
        wword_c = wdata;
        rdata_c = rword;
      end
      default: size_err_c = 1'b1;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = ((size == MEM_SZ_H) && addr_lo[0]) ||
                      ((size == MEM_SZ_W) && (addr_lo != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder: unified word array serving MemRead/MemWrite strobes.
// Optional MEM_MISALIGN_TRAP_EN (in mem_lane_align) turns misaligned accesses into errors.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic [MEMR_ADDR_W-1:0] Addr,
  input  logic [MEMR_DATA_W-1:0] WData,
  input  logic [1:0]             Size,
  input  logic                   SignExt,
  output logic [MEMR_DATA_W-1:0] RData,
  output logic                   Ready,
  output logic                   Busy,
  output logic                   Error
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MEMR_DATA_W-1:0] mem [DEPTH];

  memr_state_t            state_q, state_d;
  logic [MEMR_CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t               req_q, req_d, req_live, eff;
  logic [MEMR_DATA_W-1:0] rdata_d;
  logic                   ready_d, busy_d, error_d;
  logic                   go_resp, fault, we, oob;
  logic [29:0]            widx_full;
  logic [IDX_W-1:0]       widx;
  logic [MEMR_DATA_W-1:0] rword, wword, rdata_al;
  logic [3:0]             be;
  logic                   size_err, misalign;

  assign req_live = '{addr: Addr, wdata: WData, size: Size, sign_ext: SignExt,
                      write: MemWrite, both: MemRead & MemWrite};

  // With zero wait states the access resolves on the accept edge, so use the live request.
  assign eff       = (state_q == MEMR_IDLE) ? req_live : req_q;
  assign widx_full = eff.addr[31:2];
  assign oob       = (widx_full >= 30'(DEPTH));
  assign widx      = widx_full[IDX_W-1:0];
  assign rword     = oob ? '0 : mem[widx];
  assign fault     = eff.both | size_err | misalign | oob;

  mem_lane_align u_align (
    .addr_lo    (eff.addr[1:0]),
    .size       (eff.size),
    .sign_ext   (eff.sign_ext),
    .wdata      (eff.wdata),
    .rword      (rword),
    .be_c       (be),
    .wword_c    (wword),
    .rdata_c    (rdata_al),
    .size_err_c (size_err),
    .misalign_c (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    go_resp = 1'b0;
    ready_d = 1'b0;
    error_d = 1'b0;
    rdata_d = '0;
    case (state_q)
      MEMR_IDLE: begin
        if (MemRead || MemWrite) begin
          req_d = req_live;
          if (WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = MEMR_WAIT;
            cnt_d   = MEMR_CNT_W'(1);
          end
        end
      end
      MEMR_WAIT: begin
        if (cnt_q == MEMR_CNT_W'(WAIT_CYCLES)) go_resp = 1'b1;
        else                                   cnt_d   = cnt_q + MEMR_CNT_W'(1);
      end
      MEMR_RESP: state_d = MEMR_IDLE;
      default:   state_d = MEMR_IDLE;
    endcase
    if (go_resp) begin
      state_d = MEMR_RESP;
      cnt_d   = '0;
      ready_d = 1'b1;
      error_d = fault;
      rdata_d = (fault || eff.write) ? '0 : rdata_al;
    end
    busy_d = (state_d != MEMR_IDLE);
  end

  assign we = go_resp & eff.write & ~fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEMR_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      Ready   <= 1'b0;
      Busy    <= 1'b0;
      Error   <= 1'b0;
      RData   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      Ready   <= ready_d;
      Busy    <= busy_d;
      Error   <= error_d;
      RData   <= rdata_d;
    end
  end

  // Array is never reset; a write held off by reset is simply dropped.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder using three instances (WAIT_CYCLES 2, 0, 3) and a scoreboard.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, sext;
  logic [1:0]  sel, size;
  logic [31:0] addr, wdata;
  logic [31:0] rdat [3];
  logic [2:0]  rdy, bsy, erro;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .INIT_FILE("")) u_w2 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd && sel == 2'd0), .MemWrite(wr && sel == 2'd0),
    .Addr(addr), .WData(wdata), .Size(size), .SignExt(sext),
    .RData(rdat[0]), .Ready(rdy[0]), .Busy(bsy[0]), .Error(erro[0]));

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0), .INIT_FILE("")) u_w0 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd && sel == 2'd1), .MemWrite(wr && sel == 2'd1),
    .Addr(addr), .WData(wdata), .Size(size), .SignExt(sext),
    .RData(rdat[1]), .Ready(rdy[1]), .Busy(bsy[1]), .Error(erro[1]));

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(3), .INIT_FILE("")) u_w3 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd && sel == 2'd2), .MemWrite(wr && sel == 2'd2),
    .Addr(addr), .WData(wdata), .Size(size), .SignExt(sext),
    .RData(rdat[2]), .Ready(rdy[2]), .Busy(bsy[2]), .Error(erro[2]));

  function automatic int wc(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access into instance k, drop the strobes after the accept edge, then score the response.
  task automatic do_access(input int k, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                           input logic [31:0] er, input logic ee, input logic crd,
                           input string tag);
    exp_t e;
    bit   got;
    e.rdata = er; e.err = ee; e.chk_rd = crd; e.lat = wc(k) + 1; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    sel = 2'(k); rd = r; wr = w; addr = a; wdata = wd; size = sz; sext = sx;
    @(posedge clk);
    #1 rd = 1'b0; wr = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, " busy"}, 32'(bsy[k]), 32'd1);
      if (rdy[k]) begin
        got = 1'b1;
        e = sb.pop_front();
        check({e.tag, " latency"}, 32'(c), 32'(e.lat));
        check({e.tag, " error"}, 32'(erro[k]), 32'(e.err));
        if (e.chk_rd) check({e.tag, " rdata"}, rdat[k], e.rdata);
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $error("FAIL %s: no Ready within 20 cycles, observed 0 expected 1", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    check({tag, " ready drop"}, 32'(rdy[k]), 32'd0);
    check({tag, " busy drop"}, 32'(bsy[k]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; sel = 2'd0; addr = '0; wdata = '0;
    size = 2'b10; sext = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset ready", 32'(rdy[k]), 32'd0);
      check("reset busy", 32'(bsy[k]), 32'd0);
      check("reset error", 32'(erro[k]), 32'd0);
      check("reset rdata", rdat[k], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // WAIT_CYCLES=2 instance: lanes, extension, faults
    do_access(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, 0, "w2 word write");
    do_access(0, 1, 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 1, "w2 word read");
    do_access(0, 0, 1, 32'h11, 32'h80, 2'b00, 0, 32'h0, 0, 0, "w2 byte write");
    do_access(0, 1, 0, 32'h11, 32'h0, 2'b00, 1, 32'hFFFFFF80, 0, 1, "w2 lb");
    do_access(0, 1, 0, 32'h11, 32'h0, 2'b00, 0, 32'h00000080, 0, 1, "w2 lbu");
    do_access(0, 1, 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEAD80EF, 0, 1, "w2 word merged");
    do_access(0, 1, 0, 32'h12, 32'h0, 2'b01, 0, 32'h0000DEAD, 0, 1, "w2 lhu");
    do_access(0, 1, 0, 32'h12, 32'h0, 2'b01, 1, 32'hFFFFDEAD, 0, 1, "w2 lh");
    do_access(0, 1, 0, 32'h10, 32'h0, 2'b00, 0, 32'h000000EF, 0, 1, "w2 lbu lane0");
`ifdef MEM_MISALIGN_TRAP_EN
    do_access(0, 1, 0, 32'h13, 32'h0, 2'b01, 0, 32'h0, 1, 1, "w2 half misalign");
    do_access(0, 1, 0, 32'h11, 32'h0, 2'b10, 0, 32'h0, 1, 1, "w2 word misalign");
    do_access(0, 0, 1, 32'h13, 32'h5555, 2'b01, 0, 32'h0, 1, 0, "w2 half misalign write");
    do_access(0, 1, 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEAD80EF, 0, 1, "w2 word after trap");
`else
    do_access(0, 1, 0, 32'h13, 32'h0, 2'b01, 0, 32'h0000DEAD, 0, 1, "w2 half forced align");
    do_access(0, 1, 0, 32'h11, 32'h0, 2'b10, 0, 32'hDEAD80EF, 0, 1, "w2 word forced align");
    do_access(0, 0, 1, 32'h13, 32'h5555, 2'b01, 0, 32'h0, 0, 0, "w2 half forced write");
    do_access(0, 1, 0, 32'h10, 32'h0, 2'b10, 0, 32'h555580EF, 0, 1, "w2 word after half");
`endif
    do_access(0, 1, 0, 32'h1000, 32'h0, 2'b10, 0, 32'h0, 1, 1, "w2 out of range");
    do_access(0, 1, 0, 32'h10, 32'h0, 2'b11, 0, 32'h0, 1, 1, "w2 reserved size");

    // WAIT_CYCLES=0 instance: dual strobe fault and back-to-back held request
    do_access(1, 0, 1, 32'h20, 32'h12345678, 2'b10, 0, 32'h0, 0, 0, "w0 word write");
    do_access(1, 1, 1, 32'h20, 32'hFFFFFFFF, 2'b10, 0, 32'h0, 1, 1, "w0 both strobes");
    do_access(1, 1, 0, 32'h20, 32'h0, 2'b10, 0, 32'h12345678, 0, 1, "w0 word unchanged");

    @(negedge clk);
    sel = 2'd1; rd = 1'b1; addr = 32'h20; size = 2'b10;
    @(negedge clk);
    check("held first ready", 32'(rdy[1]), 32'd1);
    check("held first rdata", rdat[1], 32'h12345678);
    @(negedge clk);
    check("held resp gap ready", 32'(rdy[1]), 32'd0);
    check("held resp gap busy", 32'(bsy[1]), 32'd0);
    @(posedge clk);
    #1 rd = 1'b0;
    @(negedge clk);
    check("held second ready", 32'(rdy[1]), 32'd1);
    check("held second rdata", rdat[1], 32'h12345678);
    @(negedge clk);
    check("held no third", 32'(rdy[1]), 32'd0);

    // WAIT_CYCLES=3 instance: reset during WAIT drops the write
    do_access(2, 0, 1, 32'h40, 32'h11112222, 2'b10, 0, 32'h0, 0, 0, "w3 word write");
    @(negedge clk);
    sel = 2'd2; wr = 1'b1; addr = 32'h40; wdata = 32'hAAAAAAAA; size = 2'b10;
    @(posedge clk);
    #1 wr = 1'b0;
    @(negedge clk);
    check("w3 busy in wait", 32'(bsy[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("w3 reset ready", 32'(rdy[2]), 32'd0);
    check("w3 reset busy", 32'(bsy[2]), 32'd0);
    check("w3 reset error", 32'(erro[2]), 32'd0);
    check("w3 reset rdata", rdat[2], 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_access(2, 1, 0, 32'h40, 32'h0, 2'b10, 0, 32'h11112222, 0, 1, "w3 write dropped");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
